// File: rtl/result_fifo.sv
// result_fifo: buffers registered (x, z) result pairs from the arithmetic stage and
// presents them downstream over a ready/valid handshake. Pairs offered while the
// buffer is full are dropped and flagged on the sticky ovf output.
// Optional feature macro: RESULT_FIFO_CHECKSUM_EN enables a running XOR checksum
// of every accepted pair; when undefined, checksum is tied to zero.
module result_fifo #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned DEPTH     = 4,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_vld,
    input  logic [DATAWIDTH-1:0] in_x,
    input  logic [DATAWIDTH-1:0] in_z,
    output logic                 in_rdy,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [DATAWIDTH-1:0] out_x,
    output logic [DATAWIDTH-1:0] out_z,
    output logic [AW:0]          count,
    output logic                 ovf,
    input  logic                 ovf_clr,
    output logic [DATAWIDTH-1:0] checksum
);

    localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

    logic [DATAWIDTH-1:0] mem_x_q [DEPTH];
    logic [DATAWIDTH-1:0] mem_z_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 push, pop, drop;

    // Handshake flags derive from the occupancy count alone; no in->out bypass.
    assign in_rdy  = (count_q != CountFull);
    assign out_vld = (count_q != '0);
    assign out_x   = mem_x_q[rd_ptr_q];
    assign out_z   = mem_z_q[rd_ptr_q];
    assign count   = count_q;
    assign ovf     = ovf_q;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;
    assign drop = in_vld & ~in_rdy;

    // Next occupancy and sticky overflow; a drop beats a simultaneous clear.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Storage array: written at wr_ptr on push, fully cleared by reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_x_q[i] <= '0;
                mem_z_q[i] <= '0;
            end
        end else if (push) begin
            mem_x_q[wr_ptr_q] <= in_x;
            mem_z_q[wr_ptr_q] <= in_z;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count and ovf registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef RESULT_FIFO_CHECKSUM_EN
    logic [DATAWIDTH-1:0] checksum_q;

    // Running checksum over accepted pairs only: x ^ rotl(z, 1).
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            checksum_q <= '0;
        end else if (push) begin
            checksum_q <= checksum_q ^ in_x ^ {in_z[DATAWIDTH-2:0], in_z[DATAWIDTH-1]};
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_result_fifo.sv
// Self-checking bench for result_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the buffer.
module tb_result_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
`ifdef RESULT_FIFO_CHECKSUM_EN
    localparam bit CksEn = 1'b1;
`else
    localparam bit CksEn = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          in_vld = 1'b0;
    logic [DW-1:0] in_x = '0;
    logic [DW-1:0] in_z = '0;
    logic          in_rdy;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] out_x;
    logic [DW-1:0] out_z;
    logic [AW:0]   count;
    logic          ovf;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] checksum;

    result_fifo #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .in_vld(in_vld), .in_x(in_x), .in_z(in_z), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_x(out_x), .out_z(out_z), .count(count),
        .ovf(ovf), .ovf_clr(ovf_clr), .checksum(checksum)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending pairs in arrival order, sticky flag, checksum.
    logic [2*DW-1:0] mq[$];
    bit              m_ovf = 1'b0;
    logic [DW-1:0]   m_cks = '0;

    function automatic logic [DW-1:0] exp_cks();
        return CksEn ? m_cks : '0;
    endfunction

    // One clock: model decides from the pre-edge inputs, then the edge, then settle.
    task automatic tick();
        bit do_pop, do_push, do_drop;
        do_pop  = (mq.size() != 0) && out_rdy;
        do_push = in_vld && (mq.size() != DEPTH);
        do_drop = in_vld && (mq.size() == DEPTH);
        @(posedge Clk);
        #1;
        if (!Rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cks = '0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({in_x, in_z});
                m_cks = m_cks ^ in_x ^ ((in_z << 1) | (in_z >> (DW - 1)));
            end
            if (do_drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy got %b exp 1", in_rdy); end
        n_cmp++; if (out_x !== 32'h0 || out_z !== 32'h0) begin n_err++; $display("FAIL reset_data got %h/%h exp 0/0", out_x, out_z); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        n_cmp++; if (checksum !== 32'h0) begin n_err++; $display("FAIL reset_checksum got %h exp 0", checksum); end
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_vld = 1'b1; in_x = 32'h0000000A; in_z = 32'h00000005; out_rdy = 1'b0;
        tick();
        in_vld = 1'b0;
        n_cmp++; if (out_vld !== 1'b1 || count !== 3'd1) begin n_err++; $display("FAIL single_vld got vld=%b cnt=%0d exp 1/1", out_vld, count); end
        n_cmp++; if (out_x !== 32'hA || out_z !== 32'h5) begin n_err++; $display("FAIL single_data got %h/%h exp a/5", out_x, out_z); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_vld !== 1'b1 || out_x !== 32'hA || out_z !== 32'h5) begin n_err++; $display("FAIL single_hold got vld=%b %h/%h exp 1 a/5", out_vld, out_x, out_z); end
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        n_cmp++; if (out_vld !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL single_pop got vld=%b cnt=%0d exp 0/0", out_vld, count); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) begin
            in_vld = 1'b1; in_x = DW'(i); in_z = DW'(i + 'h100);
            tick();
        end
        n_cmp++; if (count !== 3'd4 || in_rdy !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL full_flags got cnt=%0d rdy=%b ovf=%b exp 4/0/0", count, in_rdy, ovf); end
        in_x = 32'd5; in_z = 32'h105;
        tick();
        in_vld = 1'b0;
        n_cmp++; if (ovf !== 1'b1 || count !== 3'd4) begin n_err++; $display("FAIL overflow got ovf=%b cnt=%0d exp 1/4", ovf, count); end
        out_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if (out_vld !== 1'b1 || out_x !== DW'(k) || out_z !== DW'(k + 'h100)) begin n_err++; $display("FAIL drain_order got vld=%b %h/%h exp 1 %h", out_vld, out_x, out_z, k); end
            tick();
        end
        out_rdy = 1'b0;
        n_cmp++; if (out_vld !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL drain_empty got vld=%b cnt=%0d exp 0/0", out_vld, count); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    endtask

    task automatic test_back_to_back();
        int exp_x;
        for (int i = 8; i <= 9; i++) begin
            in_vld = 1'b1; in_x = DW'(i); in_z = DW'(i);
            tick();
        end
        exp_x = 8;
        out_rdy = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            n_cmp++; if (out_x !== DW'(exp_x)) begin n_err++; $display("FAIL b2b_order got %0d exp %0d", out_x, exp_x); end
            exp_x++;
            in_x = DW'(i); in_z = DW'(i);
            tick();
            n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count got %0d exp 2", count); end
        end
        in_vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (out_vld !== 1'b1 || out_x !== DW'(exp_x)) begin n_err++; $display("FAIL b2b_drain got vld=%b %0d exp 1 %0d", out_vld, out_x, exp_x); end
            exp_x++;
            tick();
        end
        out_rdy = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_final got %0d exp 0", count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            in_vld = 1'b1; in_x = DW'('h20 + i); in_z = ~DW'('h20 + i); out_rdy = 1'b0;
            tick();
            in_vld = 1'b0;
            n_cmp++; if (out_vld !== 1'b1 || out_x !== DW'('h20 + i) || out_z !== ~DW'('h20 + i)) begin n_err++; $display("FAIL wrap_data got vld=%b %h/%h exp 1 %h", out_vld, out_x, out_z, 'h20 + i); end
            out_rdy = 1'b1;
            tick();
        end
        out_rdy = 1'b0;
        n_cmp++; if (count !== 3'd0 || out_vld !== 1'b0) begin n_err++; $display("FAIL wrap_final got cnt=%0d vld=%b exp 0/0", count, out_vld); end
    endtask

    task automatic test_ovf_clr();
        for (int i = 0; i < 4; i++) begin
            in_vld = 1'b1; in_x = $urandom; in_z = $urandom;
            tick();
        end
        ovf_clr = 1'b1; in_x = 32'hDEAD;
        tick();
        n_cmp++; if (ovf !== 1'b1 || count !== 3'd4) begin n_err++; $display("FAIL clr_vs_drop got ovf=%b cnt=%0d exp 1/4", ovf, count); end
        in_vld = 1'b0;
        tick();
        ovf_clr = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL clr_alone got %b exp 0", ovf); end
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({out_x, out_z} !== mq[0]) begin n_err++; $display("FAIL clr_drain got %h exp %h", {out_x, out_z}, mq[0]); end
            tick();
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            n_cmp++; if (count !== (AW + 1)'(mq.size())) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count, mq.size()); end
            n_cmp++; if (in_rdy !== (mq.size() != DEPTH) || out_vld !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_flags cyc %0d got rdy=%b vld=%b exp size %0d", c, in_rdy, out_vld, mq.size()); end
            n_cmp++; if (ovf !== m_ovf || checksum !== exp_cks()) begin n_err++; $display("FAIL rnd_ovf_cks cyc %0d got %b/%h exp %b/%h", c, ovf, checksum, m_ovf, exp_cks()); end
            if (mq.size() != 0) begin
                n_cmp++; if ({out_x, out_z} !== mq[0]) begin n_err++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, {out_x, out_z}, mq[0]); end
            end
            in_vld  = ($urandom_range(0, 99) < 55);
            out_rdy = ($urandom_range(0, 99) < 45);
            ovf_clr = ($urandom_range(0, 99) < 8);
            in_x = $urandom; in_z = $urandom;
            tick();
        end
        in_vld = 1'b0; ovf_clr = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        out_rdy = 1'b0;
    endtask

    task automatic test_async_reset();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; in_x = $urandom; in_z = $urandom;
            tick();
        end
        in_vld = 1'b0;
        n_cmp++; if (count !== 3'd3 || checksum !== exp_cks()) begin n_err++; $display("FAIL pre_reset got cnt=%0d cks=%h exp 3/%h", count, checksum, exp_cks()); end
        #3;
        Rst = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || out_vld !== 1'b0 || checksum !== 32'h0 || in_rdy !== 1'b1) begin n_err++; $display("FAIL async_reset got cnt=%0d vld=%b cks=%h rdy=%b exp 0/0/0/1", count, out_vld, checksum, in_rdy); end
        tick();
        Rst = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (out_vld !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL post_reset got vld=%b cnt=%0d exp 0/0", out_vld, count); end
        end
        out_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_wrap();
        test_ovf_clr();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
